indication_input_demux: RTL and testbench

- Parametrised successor to the single-method indication input stage.
- Accepts framed messages from a portal pipe: word 0 [31:0] is the method tag, the remaining bits are the payload.
- Buffers up to DEPTH messages and steers each one, in order, to one of NUM_METHODS indication channels.
- Unknown tags are discarded and counted, so a bad frame cannot stall the pipe.

---
 rtl/connect_pkg.sv | 24 ++
 rtl/indication_input_demux_if.sv | 39 +++
 rtl/msg_fifo.sv | 71 +++++++
 rtl/indication_input_demux.sv | 92 +++++++++
 tb/tb_indication_input_demux.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/connect_pkg.sv
// Shared portal-indication definitions: tag width and tag-to-channel decode.
package connect_pkg;

    localparam int unsigned TAG_W = 32;
    localparam int unsigned IDX_W = 4;

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] index;
    } tag_dec_t;

    // The lower bound is checked before the offset is trusted, so no tag can wrap into range.
    function automatic tag_dec_t tag_to_index(tag_t tag, tag_t base, tag_t n);
        tag_dec_t dec;
        tag_t     off;
        off       = tag - base;
        dec.valid = (tag >= base) && (off < n);
        dec.index = off[IDX_W-1:0];
        return dec;
    endfunction

endpackage

// File: rtl/indication_input_demux_if.sv
// Portal pipe in, indication channels out, plus drop reporting.
interface indication_input_demux_if #(
    parameter int unsigned NUM_METHODS = 4,
    parameter int unsigned PAYLOAD_W   = 64
);
    localparam int unsigned MSG_W = 32 + PAYLOAD_W;

    logic                   pipe_enq_ena;
    logic [MSG_W-1:0]       pipe_enq_v;
    logic                   pipe_enq_rdy;
    logic [NUM_METHODS-1:0] indication_deliver_ena;
    logic [PAYLOAD_W-1:0]   indication_deliver_v;
    logic [NUM_METHODS-1:0] indication_deliver_rdy;
    logic [15:0]            drop_count;
    logic                   drop__ENA;

    modport master (
        output pipe_enq_ena,
        output pipe_enq_v,
        input  pipe_enq_rdy,
        input  indication_deliver_ena,
        input  indication_deliver_v,
        output indication_deliver_rdy,
        input  drop_count,
        input  drop__ENA
    );

    modport slave (
        input  pipe_enq_ena,
        input  pipe_enq_v,
        output pipe_enq_rdy,
        output indication_deliver_ena,
        output indication_deliver_v,
        input  indication_deliver_rdy,
        output drop_count,
        output drop__ENA
    );

endinterface

// File: rtl/msg_fifo.sv
// Circular message buffer with occupancy count; head is read straight from storage.
module msg_fifo #(
    parameter int unsigned  WIDTH = 96,
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] enq_v_i,
    input  logic             enq_ena_i,
    output logic             enq_rdy_o,
    input  logic             deq_ena_i,
    output logic [WIDTH-1:0] first_o,
    output logic             not_empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_enq, do_deq;

    assign enq_rdy_o   = (count_q != FULL);
    assign not_empty_o = (count_q != '0);
    assign do_enq      = enq_ena_i & enq_rdy_o;
    assign do_deq      = deq_ena_i & not_empty_o;
    assign first_o     = mem_q[rptr_q];
    assign count_o     = count_q;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_enq) begin
            mem_d[wptr_q] = enq_v_i;
            wptr_d        = wptr_q + PTR_W'(1);
        end
        if (do_deq) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        if (do_enq && !do_deq) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_enq && do_deq) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; the count alone decides what is live.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/indication_input_demux.sv
// Buffers framed portal messages and steers each, in order, to its indication channel by tag.
module indication_input_demux
    import connect_pkg::*;
#(
    parameter int unsigned NUM_METHODS = 4,
    parameter int unsigned PAYLOAD_W   = 64,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TAG_BASE    = 1
) (
    input logic                     CLK,
    input logic                     RST,
    indication_input_demux_if.slave bus
);

    localparam int unsigned MSG_W = TAG_W + PAYLOAD_W;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        tag_t                 tag;
    } msg_t;

    msg_t                   head;
    tag_dec_t               dec;
    logic                   fifo_rdy;
    logic                   has_head;
    logic [CNT_W-1:0]       fifo_count;
    logic                   pop;
    logic                   drop;
    logic [NUM_METHODS-1:0] deliver_ena;
    logic [15:0]            drop_count_q, drop_count_d;
    logic                   drop_ena_q, drop_ena_d;

    msg_fifo #(
        .WIDTH (MSG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .RST         (RST),
        .enq_v_i     (bus.pipe_enq_v),
        .enq_ena_i   (bus.pipe_enq_ena),
        .enq_rdy_o   (fifo_rdy),
        .deq_ena_i   (pop),
        .first_o     (head),
        .not_empty_o (has_head),
        .count_o     (fifo_count)
    );

    always_comb begin
        dec          = tag_to_index(head.tag, tag_t'(TAG_BASE), tag_t'(NUM_METHODS));
        deliver_ena  = '0;
        drop         = 1'b0;
        if (has_head) begin
            if (dec.valid) begin
                deliver_ena = bus.indication_deliver_rdy & (NUM_METHODS'(1) << dec.index);
            end else begin
                drop = 1'b1;
            end
        end
        // Unknown tags pop unconditionally so they never block the pipe.
        pop          = (|deliver_ena) | drop;
        drop_ena_d   = drop;
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            drop_count_q <= '0;
            drop_ena_q   <= 1'b0;
        end else begin
            drop_count_q <= drop_count_d;
            drop_ena_q   <= drop_ena_d;
        end
    end

    // Occupancy and the empty flag must always agree.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (has_head == (fifo_count != '0));
        end
    end

    assign bus.pipe_enq_rdy           = fifo_rdy;
    assign bus.indication_deliver_ena = deliver_ena;
    assign bus.indication_deliver_v   = head.payload;
    assign bus.drop_count             = drop_count_q;
    assign bus.drop__ENA              = drop_ena_q;

endmodule

// File: tb/tb_indication_input_demux.sv
// Directed plus random stimulus against a queue-based reference model of the demux.
module tb_indication_input_demux;

    localparam int unsigned NM       = 4;
    localparam int unsigned PW       = 64;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned TAG_BASE = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    indication_input_demux_if #(.NUM_METHODS(NM), .PAYLOAD_W(PW)) bus ();

    indication_input_demux #(
        .NUM_METHODS (NM),
        .PAYLOAD_W   (PW),
        .DEPTH       (DEPTH),
        .TAG_BASE    (TAG_BASE)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [95:0] q_model[$];
    logic [15:0] m_drop_count = '0;
    logic        m_drop_pulse = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit head_valid();
        longint t;
        t = longint'(q_model[0][31:0]);
        return (t >= TAG_BASE) && (t < TAG_BASE + NM);
    endfunction

    // Expected strobe for the current head under the current ready vector.
    function automatic logic [NM-1:0] exp_ena();
        int idx;
        if (q_model.size() == 0) return '0;
        if (!head_valid()) return '0;
        idx = int'(q_model[0][31:0]) - int'(TAG_BASE);
        if (bus.indication_deliver_rdy[idx]) return NM'(1) << idx;
        return '0;
    endfunction

    task automatic check_outputs();
        check("enq_rdy", 64'(bus.pipe_enq_rdy), 64'(q_model.size() != DEPTH));
        check("deliver_ena", 64'(bus.indication_deliver_ena), 64'(exp_ena()));
        if (q_model.size() != 0) begin
            check("deliver_v", bus.indication_deliver_v, q_model[0][95:32]);
        end
        check("drop_ena", 64'(bus.drop__ENA), 64'(m_drop_pulse));
        check("drop_count", 64'(bus.drop_count), 64'(m_drop_count));
    endtask

    task automatic update_model();
        bit full;
        if (rst) begin
            q_model.delete();
            m_drop_count = '0;
            m_drop_pulse = 1'b0;
            return;
        end
        full         = (q_model.size() == DEPTH);
        m_drop_pulse = 1'b0;
        if (q_model.size() != 0) begin
            if (!head_valid()) begin
                m_drop_pulse = 1'b1;
                if (m_drop_count != 16'hFFFF) m_drop_count++;
                void'(q_model.pop_front());
            end else if (exp_ena() != '0) begin
                void'(q_model.pop_front());
            end
        end
        if (bus.pipe_enq_ena && !full) q_model.push_back(bus.pipe_enq_v);
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic send(input logic [31:0] tag, input logic [63:0] payload);
        bus.pipe_enq_ena = 1'b1;
        bus.pipe_enq_v   = {payload, tag};
        tick();
        bus.pipe_enq_ena = 1'b0;
    endtask

    function automatic logic [31:0] rand_tag();
        if ($urandom_range(0, 7) == 0) return $urandom;
        return 32'($urandom_range(1, 4));
    endfunction

    initial begin
        bus.pipe_enq_ena           = 1'b0;
        bus.pipe_enq_v             = '0;
        bus.indication_deliver_rdy = '0;

        // Reset
        rst = 1'b1;
        @(posedge clk);
        update_model();
        #1;
        tick();
        rst = 1'b0;
        #3;
        check("reset_rdy", 64'(bus.pipe_enq_rdy), 64'd1);
        check("reset_ena", 64'(bus.indication_deliver_ena), 64'd0);
        check("reset_drop_count", 64'(bus.drop_count), 64'd0);
        check("reset_drop_ena", 64'(bus.drop__ENA), 64'd0);
        tick();

        // Basic delivery, one cycle after the write edge
        bus.indication_deliver_rdy = 4'b1111;
        send(32'd1, 64'h0000_0005_0000_0007);
        #3;
        check("basic_ena", 64'(bus.indication_deliver_ena), 64'(4'b0001));
        check("basic_v", bus.indication_deliver_v, 64'h0000_0005_0000_0007);
        tick();
        tick();

        // Fill to full, extra ENA ignored, then drain in order
        bus.indication_deliver_rdy = 4'b0000;
        for (int i = 1; i <= 4; i++) send(32'(i), 64'(i) * 64'h1111);
        #3;
        check("full_rdy", 64'(bus.pipe_enq_rdy), 64'd0);
        send(32'd2, 64'hDEAD_BEEF);
        bus.indication_deliver_rdy = 4'b1111;
        repeat (6) tick();

        // Head-of-line blocking
        bus.indication_deliver_rdy = 4'b0001;
        send(32'd2, 64'hAAAA);
        send(32'd1, 64'hBBBB);
        repeat (3) tick();
        bus.indication_deliver_rdy = 4'b0011;
        repeat (3) tick();

        // Unknown tags
        bus.indication_deliver_rdy = 4'b1111;
        send(32'd0, 64'h10);
        send(32'd7, 64'h70);
        send(32'd3, 64'h30);
        repeat (3) tick();
        #3;
        check("unknown_drop_count", 64'(bus.drop_count), 64'd2);

        // Simultaneous enqueue and pop with pointer wrap
        bus.indication_deliver_rdy = 4'b0000;
        send(32'd1, 64'h1);
        send(32'd2, 64'h2);
        bus.indication_deliver_rdy = 4'b1111;
        for (int i = 0; i < 12; i++) send(32'($urandom_range(1, 4)), {$urandom, $urandom});
        repeat (4) tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus.pipe_enq_ena           = ($urandom_range(0, 2) != 0);
            bus.pipe_enq_v             = {$urandom, $urandom, rand_tag()};
            bus.indication_deliver_rdy = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
            tick();
        end
        bus.pipe_enq_ena           = 1'b0;
        bus.indication_deliver_rdy = 4'b1111;
        repeat (6) tick();

        // Reset mid-operation discards queued messages
        bus.indication_deliver_rdy = 4'b0000;
        send(32'd1, 64'h111);
        send(32'd2, 64'h222);
        send(32'd3, 64'h333);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #3;
        check("midrst_rdy", 64'(bus.pipe_enq_rdy), 64'd1);
        check("midrst_drop_count", 64'(bus.drop_count), 64'd0);
        check("midrst_ena", 64'(bus.indication_deliver_ena), 64'd0);
        bus.indication_deliver_rdy = 4'b1111;
        repeat (3) tick();
        #3;
        check("midrst_no_ena", 64'(bus.indication_deliver_ena), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
